// File: rtl/ddr_app_ctrl.sv
// Single-request-at-a-time bridge from a simple valid/ready user port to the MIG UI.
// Reads return through a first-word-fall-through FIFO sized by the read-credit limit.
module ddr_app_ctrl #(
    parameter int unsigned RSP_DEPTH = 16
) (
    input  logic         ui_clk,
    input  logic         ui_clk_sync_rst,
    input  logic         init_calib_complete,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [27:0]  req_addr,
    input  logic [511:0] req_wdata,
    input  logic [63:0]  req_wmask,
    output logic         rsp_valid,
    output logic [511:0] rsp_data,
    input  logic         rsp_ready,
    output logic [27:0]  app_addr,
    output logic [2:0]   app_cmd,
    output logic         app_en,
    output logic [511:0] app_wdf_data,
    output logic         app_wdf_end,
    output logic [63:0]  app_wdf_mask,
    output logic         app_wdf_wren,
    input  logic [511:0] app_rd_data,
    input  logic         app_rd_data_valid,
    input  logic         app_rdy,
    input  logic         app_wdf_rdy
);

    localparam int unsigned AW = 28;
    localparam int unsigned DW = 512;
    localparam int unsigned MW = 64;
    localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    typedef enum logic [1:0] {IDLE, WR, RD} state_t;

    state_t          state;
    state_t          state_nxt;
    logic            en_nxt;
    logic            wren_nxt;
    logic [AW-1:0]   addr_nxt;
    logic [2:0]      cmd_nxt;
    logic [DW-1:0]   wdata_nxt;
    logic [MW-1:0]   wmask_nxt;

    logic            accept;
    logic            rd_accept;
    logic            rd_retire;
    logic            rsp_pop;
    logic            fifo_push;
    logic [CW-1:0]   credits;
    logic [CW-1:0]   pending;
    logic [CW-1:0]   wr_ptr;
    logic [CW-1:0]   rd_ptr;
    logic [DW-1:0]   mem [RSP_DEPTH];

    // Held low during reset so nothing is accepted while the block is being cleared.
    assign req_ready = ~ui_clk_sync_rst & (state == IDLE) & init_calib_complete
                     & (credits < CW'(RSP_DEPTH));
    assign accept    = req_valid & req_ready;
    assign rd_accept = accept & ~req_write;
    assign rd_retire = (state == RD) & app_en & app_rdy;
    assign rsp_pop   = rsp_valid & rsp_ready;
    assign fifo_push = app_rd_data_valid & (pending != '0);

    // Next state and next values of the registered MIG command/write-data outputs.
    always_comb begin
        state_nxt = state;
        en_nxt    = app_en;
        wren_nxt  = app_wdf_wren;
        addr_nxt  = app_addr;
        cmd_nxt   = app_cmd;
        wdata_nxt = app_wdf_data;
        wmask_nxt = app_wdf_mask;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = req_write ? WR : RD;
                    en_nxt    = 1'b1;
                    wren_nxt  = req_write;
                    addr_nxt  = req_addr;
                    cmd_nxt   = req_write ? CMD_WR : CMD_RD;
                    wdata_nxt = req_wdata;
                    wmask_nxt = req_wmask;
                end
            end
            WR: begin
                // Command and data channels retire independently.
                en_nxt   = app_en & ~app_rdy;
                wren_nxt = app_wdf_wren & ~app_wdf_rdy;
                if (!en_nxt && !wren_nxt) begin
                    state_nxt = IDLE;
                end
            end
            RD: begin
                en_nxt   = app_en & ~app_rdy;
                wren_nxt = 1'b0;
                if (!en_nxt) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                en_nxt    = 1'b0;
                wren_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            state        <= IDLE;
            app_en       <= 1'b0;
            app_wdf_wren <= 1'b0;
            app_wdf_end  <= 1'b0;
            app_addr     <= '0;
            app_cmd      <= '0;
            app_wdf_data <= '0;
            app_wdf_mask <= '0;
        end else begin
            state        <= state_nxt;
            app_en       <= en_nxt;
            app_wdf_wren <= wren_nxt;
            app_wdf_end  <= wren_nxt;
            app_addr     <= addr_nxt;
            app_cmd      <= cmd_nxt;
            app_wdf_data <= wdata_nxt;
            app_wdf_mask <= wmask_nxt;
        end
    end

    // Credits bound reads in flight plus data parked in the FIFO; pending tracks issued reads.
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            credits <= '0;
            pending <= '0;
        end else begin
            case ({rd_accept, rsp_pop})
                2'b10:   credits <= credits + CW'(1);
                2'b01:   credits <= credits - CW'(1);
                default: credits <= credits;
            endcase
            case ({rd_retire, fifo_push})
                2'b10:   pending <= pending + CW'(1);
                2'b01:   pending <= pending - CW'(1);
                default: pending <= pending;
            endcase
        end
    end

    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= wr_ptr + CW'(1);
            end
            if (rsp_pop) begin
                rd_ptr <= rd_ptr + CW'(1);
            end
        end
    end

    always_ff @(posedge ui_clk) begin
        if (fifo_push) begin
            mem[wr_ptr[PW-1:0]] <= app_rd_data;
        end
    end

    assign rsp_valid = (wr_ptr != rd_ptr);
    assign rsp_data  = rsp_valid ? mem[rd_ptr[PW-1:0]] : '0;

endmodule
